stopwatch_time_counter: RTL and testbench
=========================================

Name: stopwatch_time_counter

Overview:
Time-base and digit counter driven by the stopwatch control FSM's o_run_on / o_clr_on outputs. It divides the system clock into 10 ms ticks and accumulates centiseconds, seconds and minutes (00:00.00 to 59:59.99). Outputs are binary digit values that feed the display/FND driver stage directly downstream.

Parameters:
CLK_HZ, 100_000_000, system clock frequency in Hz
TICK_HZ, 100, centisecond tick rate in Hz; DIV = CLK_HZ/TICK_HZ, must be integer and >= 2
DIV_W, 24, prescaler width; must satisfy 2**DIV_W >= DIV

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
i_run  input  1  level; 1 = counting enabled (from FSM o_run_on)
i_clear  input  1  level; 1 = hold all counts at zero (from FSM o_clr_on)
o_csec  output  7  centiseconds, 0..99
o_sec  output  6  seconds, 0..59
o_min  output  6  minutes, 0..59
o_tick  output  1  one-cycle pulse in the cycle after o_csec changes due to counting
o_rollover  output  1  one-cycle pulse in the cycle after 59:59.99 wraps to 00:00.00

Behaviour:
- Interface: reset is asynchronous and active-high; clock is clk. All state updates on the rising edge of clk.
- Reset: prescaler=0, o_csec=0, o_sec=0, o_min=0, o_tick=0, o_rollover=0.
- Priority per edge: i_clear > i_run > hold.
- i_clear=1: prescaler, o_csec, o_sec and o_min go to 0 on the next edge and stay there while asserted, regardless of i_run. o_tick and o_rollover are 0.
- i_run=1, i_clear=0: if prescaler==DIV-1, prescaler<=0 and the centisecond advances on the same edge; otherwise prescaler<=prescaler+1.
- First advance occurs DIV edges after i_run rises from a cleared state.
- i_run=0, i_clear=0: all counters and the prescaler hold. Pause keeps the fractional prescaler count, so resume completes the partial tick.
- Advance chain:
  - o_csec 99->0 carries to o_sec.
  - o_sec 59->0 carries to o_min.
  - o_min 59->0 wraps the whole value to 00:00.00 and asserts o_rollover.
  - All carries take effect on the same edge, with no ripple latency.
- o_tick and o_rollover are registered. Each is high for exactly the one cycle after the advancing edge.
- Counter values never exceed their maxima. An out-of-range value (possible only via an illegal force) is treated as the maximum and wraps to 0 on the next advance.
- Mid-operation reset: asynchronous clear of all registers, including a pending tick/rollover pulse.
- Clear asserted on the same edge as a tick: clear wins; no o_tick pulse.
- Widths: internal compares are unsigned at the declared widths. There are no arithmetic overflows beyond wrap.

Decomposition:
- Shared package stopwatch_pkg: CSEC_MAX=99, SEC_MAX=59, MIN_MAX=59, CSEC_W=7, SEC_W=6, MIN_W=6.
- One sub-module, stopwatch_mod_counter (parameters MAX, W):
  - Inputs: clk, reset, clr, inc.
  - Outputs: count, carry (combinational: inc && count==MAX).
  - Instantiated three times and chained via carry.
- The prescaler stays in the top module.

Test Plan:
- Reset then idle: reset=1 for 3 cycles, release with i_run=0 -> all outputs 0, o_tick never asserts over 1000 cycles.
- Basic count (CLK_HZ=1000, TICK_HZ=100, DIV=10): raise i_run at cycle 0 -> o_csec=1 after edge 10, o_tick pulses once per 10 cycles, o_csec=37 after 370 cycles.
- Pause/resume (DIV=10): run 15 cycles (csec=1, prescaler=5), drop i_run for 50 cycles -> values frozen; re-assert -> o_csec=2 exactly 5 cycles later.
- Carry chain: force state to 00:59.99 with prescaler=DIV-1, run one edge -> 01:00.00 on the same edge, o_tick=1 next cycle.
- Rollover: from 59:59.99 with prescaler=DIV-1 -> 00:00.00, o_rollover=1 for exactly one cycle, counting continues.
- Clear priority: i_run=1 and i_clear=1 at 12:34.56 -> all zero after one edge, stay zero, no o_tick; on i_clear=0 with i_run=1, first advance DIV cycles later. Also: async reset mid-count returns all outputs to 0 immediately.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: digit limits and widths shared by the stopwatch time counter and its digit counters
package stopwatch_pkg;
  localparam int CSEC_MAX = 99;
  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;
  localparam int CSEC_W = 7;
  localparam int SEC_W = 6;
  localparam int MIN_W = 6;
endpackage

// File: rtl/stopwatch_mod_counter.sv
// stopwatch_mod_counter: modulo-(MAX+1) digit counter; clk/reset(async), clr, inc in; count and combinational carry out
module stopwatch_mod_counter
  import stopwatch_pkg::*;
#(
  parameter int MAX = CSEC_MAX,
  parameter int W = CSEC_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         carry
);
  logic at_max;
  assign at_max = count >= W'(MAX);
  assign carry = inc && at_max;
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else if (clr) count <= '0;
    else if (inc) count <= at_max ? '0 : count + 1'b1;
endmodule

// File: rtl/stopwatch_time_counter.sv
// stopwatch_time_counter: 10 ms prescaler plus csec/sec/min chain; clk, reset(async), i_run, i_clear in; o_csec, o_sec, o_min, o_tick, o_rollover out
module stopwatch_time_counter
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int TICK_HZ = 100,
  parameter int DIV_W = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_run,
  input  logic              i_clear,
  output logic [CSEC_W-1:0] o_csec,
  output logic [SEC_W-1:0]  o_sec,
  output logic [MIN_W-1:0]  o_min,
  output logic              o_tick,
  output logic              o_rollover
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  logic [DIV_W-1:0] prescaler;
  logic adv, csec_carry, sec_carry, min_carry;
  assign adv = i_run && !i_clear && prescaler >= DIV_W'(DIV - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      prescaler <= '0;
      o_tick <= 1'b0;
      o_rollover <= 1'b0;
    end else begin
      prescaler <= (i_clear || adv) ? '0 : i_run ? prescaler + 1'b1 : prescaler;
      o_tick <= adv;
      o_rollover <= min_carry;
    end
  stopwatch_mod_counter #(.MAX(CSEC_MAX), .W(CSEC_W)) u_csec (
    .clk(clk), .reset(reset), .clr(i_clear), .inc(adv), .count(o_csec), .carry(csec_carry)
  );
  stopwatch_mod_counter #(.MAX(SEC_MAX), .W(SEC_W)) u_sec (
    .clk(clk), .reset(reset), .clr(i_clear), .inc(csec_carry), .count(o_sec), .carry(sec_carry)
  );
  stopwatch_mod_counter #(.MAX(MIN_MAX), .W(MIN_W)) u_min (
    .clk(clk), .reset(reset), .clr(i_clear), .inc(sec_carry), .count(o_min), .carry(min_carry)
  );
endmodule

// File: tb/tb_stopwatch_time_counter.sv
// tb_stopwatch_time_counter: randomized bench comparing the stopwatch counter against a total-centisecond model
module tb_stopwatch_time_counter;
  localparam int DIV = 10;
  localparam int TOTAL = 360000;
  logic clk = 1'b0, reset = 1'b0, i_run = 1'b0, i_clear = 1'b0;
  logic [6:0] o_csec;
  logic [5:0] o_sec, o_min;
  logic o_tick, o_rollover;
  int mt = 0, mp = 0, ld_t = 0, ld_p = 0, ld_seq = 0, ld_seen = 0;
  bit mtick = 1'b0, mroll = 1'b0;
  int pin_seq = 0, pin_seen = 0, pc, ps, pm, pt, pr;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  stopwatch_time_counter #(.CLK_HZ(1000), .TICK_HZ(100), .DIV_W(24)) dut (
    .clk(clk), .reset(reset), .i_run(i_run), .i_clear(i_clear),
    .o_csec(o_csec), .o_sec(o_sec), .o_min(o_min), .o_tick(o_tick), .o_rollover(o_rollover)
  );
  always @(posedge clk or posedge reset) begin
    if (ld_seq != ld_seen) begin
      mt = ld_t;
      mp = ld_p;
      ld_seen = ld_seq;
    end
    if (reset) begin
      mt = 0; mp = 0; mtick = 0; mroll = 0;
    end else if (i_clear) begin
      mt = 0; mp = 0; mtick = 0; mroll = 0;
    end else if (i_run && mp == DIV - 1) begin
      mp = 0;
      mt = (mt + 1) % TOTAL;
      mtick = 1;
      mroll = (mt == 0);
    end else begin
      if (i_run) mp = mp + 1;
      mtick = 0;
      mroll = 0;
    end
  end
  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
  endtask
  always begin
    @(negedge clk or posedge reset);
    if (reset) #1;
    chk("csec", o_csec, mt % 100);
    chk("sec", o_sec, (mt / 100) % 60);
    chk("min", o_min, mt / 6000);
    chk("tick", o_tick, mtick);
    chk("rollover", o_rollover, mroll);
    if (pin_seq != pin_seen) begin
      pin_seen = pin_seq;
      chk("pin_csec", o_csec, pc);
      chk("pin_sec", o_sec, ps);
      chk("pin_min", o_min, pm);
      chk("pin_tick", o_tick, pt);
      chk("pin_rollover", o_rollover, pr);
    end
  end
  task automatic pin(input int c, input int s, input int m, input int t, input int r);
    pc = c; ps = s; pm = m; pt = t; pr = r;
    pin_seq++;
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
  endtask
  task automatic drv(input bit r, input bit c);
    @(negedge clk);
    #1;
    i_run = r;
    i_clear = c;
  endtask
  task automatic set_state(input int t, input int p);
    @(negedge clk);
    #2;
    force dut.u_csec.count = 7'(t % 100);
    force dut.u_sec.count = 6'((t / 100) % 60);
    force dut.u_min.count = 6'(t / 6000);
    force dut.prescaler = 24'(p);
    #1;
    release dut.u_csec.count;
    release dut.u_sec.count;
    release dut.u_min.count;
    release dut.prescaler;
    ld_t = t;
    ld_p = p;
    ld_seq++;
  endtask
  initial begin
    reset = 1'b1;
    step(3);
    @(negedge clk);
    #1 reset = 1'b0;
    step(1000);
    pin(0, 0, 0, 0, 0);
    drv(1, 0);
    step(370);
    pin(37, 0, 0, 1, 0);
    drv(0, 1);
    drv(1, 0);
    step(15);
    pin(1, 0, 0, 0, 0);
    drv(0, 0);
    step(50);
    pin(1, 0, 0, 0, 0);
    drv(1, 0);
    step(5);
    pin(2, 0, 0, 1, 0);
    drv(0, 0);
    set_state(5999, 9);
    drv(1, 0);
    step(1);
    pin(0, 0, 1, 1, 0);
    drv(0, 0);
    set_state(TOTAL - 1, 9);
    drv(1, 0);
    step(1);
    pin(0, 0, 0, 1, 1);
    step(1);
    pin(0, 0, 0, 0, 0);
    step(25);
    pin(2, 0, 0, 0, 0);
    drv(0, 0);
    set_state(75456, 9);
    pin(56, 34, 12, 0, 0);
    drv(1, 1);
    step(3);
    pin(0, 0, 0, 0, 0);
    drv(1, 0);
    step(9);
    pin(0, 0, 0, 0, 0);
    step(1);
    pin(1, 0, 0, 1, 0);
    step(29);
    @(negedge clk);
    #2 reset = 1'b1;
    pin(0, 0, 0, 0, 0);
    step(2);
    @(negedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) set_state($urandom_range(0, TOTAL - 1), $urandom_range(0, DIV - 1));
      @(negedge clk);
      #1;
      i_clear = ($urandom_range(0, 99) < 3);
      i_run = ($urandom_range(0, 99) < 85);
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b1;
        #2 reset = 1'b0;
      end
    end
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
